// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, FSM states, size limits.
// Latency: none (declarations only).
// Backpressure: not applicable.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package alu_pkg;

  // Largest number of requesters the arbiter is built for.
  localparam int ALU_ARB_MAX_REQ = 8;

  // ALU op codes; 11..15 are unused and produce zero.
  localparam logic [3:0] ALU_CTRL_ADD = 4'd0;
  localparam logic [3:0] ALU_CTRL_SUB = 4'd1;
  localparam logic [3:0] ALU_CTRL_MUL = 4'd2;
  localparam logic [3:0] ALU_CTRL_DIV = 4'd3;
  localparam logic [3:0] ALU_CTRL_REM = 4'd4;
  localparam logic [3:0] ALU_CTRL_AND = 4'd5;
  localparam logic [3:0] ALU_CTRL_OR  = 4'd6;
  localparam logic [3:0] ALU_CTRL_XOR = 4'd7;
  localparam logic [3:0] ALU_CTRL_SLL = 4'd8;
  localparam logic [3:0] ALU_CTRL_SRL = 4'd9;
  localparam logic [3:0] ALU_CTRL_SLT = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared ALU arbiter.
// Latency: none (wires only).
// Backpressure: valid/ready per requester on both request and response sides.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]                  Req_Valid;
  logic [NUM_REQ-1:0]                  Req_Ready;
  logic [NUM_REQ-1:0][`WORD_SIZE-1:0]  Req_In1;
  logic [NUM_REQ-1:0][`WORD_SIZE-1:0]  Req_In2;
  logic [NUM_REQ-1:0][3:0]             Req_Control;
  logic [NUM_REQ-1:0]                  Rsp_Valid;
  logic [`WORD_SIZE-1:0]               Rsp_Data;
  logic [NUM_REQ-1:0]                  Rsp_Ready;
  logic                                Busy;

  // Requester side.
  modport master (
    output Req_Valid, Req_In1, Req_In2, Req_Control, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Data, Busy
  );

  // Arbiter side.
  modport slave (
    input  Req_Valid, Req_In1, Req_In2, Req_Control, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Data, Busy
  );
endinterface

// File: rtl/alu_share_arbiter_rr_grant.sv
// Round-robin grant: first set request at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is used.
module rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] j;
  logic             found;

  // Walk upward from ptr and take the first requester that is asking.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[j]) begin
        found      = 1'b1;
        gnt[j]     = 1'b1;
        gnt_idx    = j;
      end
    end
  end

  assign gnt_vld = |req;

endmodule

// File: rtl/arith_logic_unit.sv
// Combinational integer ALU, unsigned semantics, results truncated to WORD_SIZE.
// Latency: purely combinational.
// Backpressure: none.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module arith_logic_unit
  import alu_pkg::*;
(
  input  logic [`WORD_SIZE-1:0] In1,
  input  logic [`WORD_SIZE-1:0] In2,
  input  logic [3:0]            Control,
  output logic [`WORD_SIZE-1:0] Result
);

  // Decode the op code; unused codes fall through to zero.
  always_comb begin
    Result = '0;
    case (Control)
      ALU_CTRL_ADD: Result = In1 + In2;
      ALU_CTRL_SUB: Result = In1 - In2;
      ALU_CTRL_MUL: Result = In1 * In2;
      ALU_CTRL_DIV: Result = In1 / In2;
      ALU_CTRL_REM: Result = In1 % In2;
      ALU_CTRL_AND: Result = In1 & In2;
      ALU_CTRL_OR:  Result = In1 | In2;
      ALU_CTRL_XOR: Result = In1 ^ In2;
      ALU_CTRL_SLL: Result = In1 << In2;
      ALU_CTRL_SRL: Result = In1 >> In2;
      ALU_CTRL_SLT: Result = {{(`WORD_SIZE-1){1'b0}}, (In1 < In2)};
      default:      Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters, round-robin, one op in flight (ALU_ARB_DIV_ZERO_EN: defined divide-by-zero results).
// Latency: grant in T, result captured end of T+1, Rsp_Valid from T+2; at best one op per 3 cycles.
// Backpressure: result held in RESP until the owner's Rsp_Ready; no new grants until then.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input logic               Clk,
  input logic               Reset,
  alu_share_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > ALU_ARB_MAX_REQ) begin : g_bad_num_req
    $error("alu_share_arbiter: NUM_REQ must be in 2..8");
  end

  alu_arb_state_t        state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      owner;
  logic [`WORD_SIZE-1:0] op_in1;
  logic [`WORD_SIZE-1:0] op_in2;
  logic [3:0]            op_ctrl;
  logic [`WORD_SIZE-1:0] rsp_data;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic                  busy;

  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_vld;
  logic [`WORD_SIZE-1:0] alu_result;
  logic [`WORD_SIZE-1:0] exec_result;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .req     (bus.Req_Valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  arith_logic_unit u_alu (
    .In1     (op_in1),
    .In2     (op_in2),
    .Control (op_ctrl),
    .Result  (alu_result)
  );

  // Result to capture in EXEC, optionally overriding divide-by-zero.
  always_comb begin
    exec_result = alu_result;
`ifdef ALU_ARB_DIV_ZERO_EN
    if (op_in2 == '0) begin
      if (op_ctrl == ALU_CTRL_DIV) begin
        exec_result = '1;
      end else if (op_ctrl == ALU_CTRL_REM) begin
        exec_result = op_in1;
      end
    end
`endif
  end

  // Arbiter FSM: grant and latch in IDLE, capture in EXEC, hold result in RESP.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      op_in1    <= '0;
      op_in2    <= '0;
      op_ctrl   <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            owner   <= gnt_idx;
            op_in1  <= bus.Req_In1[gnt_idx];
            op_in2  <= bus.Req_In2[gnt_idx];
            op_ctrl <= bus.Req_Control[gnt_idx];
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= exec_result;
          rsp_valid <= NUM_REQ'(1) << owner;
          state     <= RESP;
        end
        RESP: begin
          // Only the owner's accept bit matters.
          if (bus.Rsp_Ready[owner]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            rr_ptr    <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Req_Ready = (state == IDLE) ? gnt : '0;
  assign bus.Rsp_Valid = rsp_valid;
  assign bus.Rsp_Data  = rsp_data;
  assign bus.Busy      = busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters.
// Latency: checks grant in T, result at T+2.
// Backpressure: exercises response stalls and non-owner accept pulses.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NR = 2;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_pass;

  alu_share_arbiter_if #(.NUM_REQ(NR)) bus ();

  alu_share_arbiter #(.NUM_REQ(NR)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One complete op from a single requester, owner accepts in the first RESP cycle.
  task automatic run_op(input string tag, input bit r, input logic [3:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [1:0] oh;
    oh = 2'b01 << r;
    bus.Req_Valid      = oh;
    bus.Req_In1[r]     = `WORD_SIZE'(a);
    bus.Req_In2[r]     = `WORD_SIZE'(b);
    bus.Req_Control[r] = ctrl;
    #1 chk({tag, "_ready"}, 32'(bus.Req_Ready), 32'(oh));
    @(negedge Clk);
    chk({tag, "_busy_exec"}, 32'(bus.Busy), 32'd1);
    bus.Req_Valid = '0;
    @(negedge Clk);
    chk({tag, "_rsp_valid"}, 32'(bus.Rsp_Valid), 32'(oh));
    chk({tag, "_rsp_data"}, 32'(bus.Rsp_Data), exp);
    bus.Rsp_Ready = oh;
    @(negedge Clk);
    bus.Rsp_Ready = '0;
    chk({tag, "_busy_done"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset            = 1'b1;
    bus.Req_Valid    = '0;
    bus.Req_In1      = '0;
    bus.Req_In2      = '0;
    bus.Req_Control  = '0;
    bus.Rsp_Ready    = '0;
    repeat (2) @(negedge Clk);

    // Reset state
    chk("rst_req_ready", 32'(bus.Req_Ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.Rsp_Valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.Rsp_Data), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Single request: ADD 5+7 on requester 0
    run_op("single_add", 1'b0, ALU_CTRL_ADD, 32'd5, 32'd7, 32'd12);

    // Response back-pressure: requester 1 owns ADD 100+23, requester 0 waits
    bus.Req_Valid      = 2'b10;
    bus.Req_In1[1]     = `WORD_SIZE'(100);
    bus.Req_In2[1]     = `WORD_SIZE'(23);
    bus.Req_Control[1] = ALU_CTRL_ADD;
    #1 chk("bp_grant1", 32'(bus.Req_Ready), 32'h2);
    @(negedge Clk);
    bus.Req_Valid      = 2'b01;
    bus.Req_In1[0]     = `WORD_SIZE'(32'hF0);
    bus.Req_In2[0]     = `WORD_SIZE'(32'hFF);
    bus.Req_Control[0] = ALU_CTRL_XOR;
    #1 chk("bp_no_ready_exec", 32'(bus.Req_Ready), 32'd0);
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(bus.Rsp_Valid), 32'h2);
      chk("bp_hold_data", 32'(bus.Rsp_Data), 32'd123);
      chk("bp_no_ready", 32'(bus.Req_Ready), 32'd0);
      chk("bp_busy", 32'(bus.Busy), 32'd1);
      bus.Rsp_Ready = (i == 2) ? 2'b01 : 2'b00;
      @(negedge Clk);
    end
    chk("bp_after_stall_valid", 32'(bus.Rsp_Valid), 32'h2);
    bus.Rsp_Ready = 2'b10;
    @(negedge Clk);
    bus.Rsp_Ready = '0;
    chk("bp_released_valid", 32'(bus.Rsp_Valid), 32'd0);
    #1 chk("bp_next_grant0", 32'(bus.Req_Ready), 32'h1);
    @(negedge Clk);
    bus.Req_Valid = '0;
    @(negedge Clk);
    chk("xor_rsp_valid", 32'(bus.Rsp_Valid), 32'h1);
    chk("xor_rsp_data", 32'(bus.Rsp_Data), 32'h0F);
    bus.Rsp_Ready = 2'b01;
    @(negedge Clk);
    bus.Rsp_Ready = '0;

    // Contention from a fresh reset: grants alternate 0,1,0,1
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("cont_rst_busy", 32'(bus.Busy), 32'd0);
    bus.Req_Valid      = 2'b11;
    bus.Rsp_Ready      = 2'b11;
    bus.Req_In1[0]     = `WORD_SIZE'(10);
    bus.Req_In2[0]     = `WORD_SIZE'(3);
    bus.Req_Control[0] = ALU_CTRL_SUB;
    bus.Req_In1[1]     = `WORD_SIZE'(6);
    bus.Req_In2[1]     = `WORD_SIZE'(7);
    bus.Req_Control[1] = ALU_CTRL_MUL;
    for (int k = 0; k < 4; k++) begin
      #1 chk("cont_grant", 32'(bus.Req_Ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      @(negedge Clk);
      @(negedge Clk);
      chk("cont_rsp_valid", 32'(bus.Rsp_Valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("cont_rsp_data", 32'(bus.Rsp_Data), (k % 2 == 0) ? 32'd7 : 32'd42);
      @(negedge Clk);
    end
    bus.Req_Valid = '0;
    bus.Rsp_Ready = '0;

    // Op coverage
    run_op("sll",    1'b1, ALU_CTRL_SLL, 32'd1,    32'd4,  32'd16);
    run_op("slt",    1'b0, ALU_CTRL_SLT, 32'd3,    32'd5,  32'd1);
    run_op("slt_ge", 1'b1, ALU_CTRL_SLT, 32'd5,    32'd3,  32'd0);
    run_op("ill13",  1'b1, 4'd13,        32'd9,    32'd4,  32'd0);
    run_op("and",    1'b0, ALU_CTRL_AND, 32'hC,    32'hA,  32'h8);
    run_op("or",     1'b1, ALU_CTRL_OR,  32'hC,    32'hA,  32'hE);
    run_op("div",    1'b0, ALU_CTRL_DIV, 32'd100,  32'd7,  32'd14);
    run_op("rem",    1'b1, ALU_CTRL_REM, 32'd100,  32'd7,  32'd2);
`ifdef ALU_ARB_DIV_ZERO_EN
    run_op("div0",   1'b0, ALU_CTRL_DIV, 32'd9,    32'd0,  32'(`WORD_SIZE'('1)));
    run_op("rem0",   1'b1, ALU_CTRL_REM, 32'd9,    32'd0,  32'd9);
`endif
    run_op("srl",    1'b0, ALU_CTRL_SRL, 32'h80,   32'd3,  32'h10);

    // Reset during EXEC: pointer now favours requester 1, op in flight is dropped
    bus.Req_Valid      = 2'b10;
    bus.Req_In1[1]     = `WORD_SIZE'(1);
    bus.Req_In2[1]     = `WORD_SIZE'(1);
    bus.Req_Control[1] = ALU_CTRL_ADD;
    #1 chk("rst_exec_grant1", 32'(bus.Req_Ready), 32'h2);
    @(negedge Clk);
    chk("rst_exec_busy", 32'(bus.Busy), 32'd1);
    Reset         = 1'b1;
    bus.Req_Valid = '0;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst_exec_busy0", 32'(bus.Busy), 32'd0);
    chk("rst_exec_valid0", 32'(bus.Rsp_Valid), 32'd0);
    chk("rst_exec_data0", 32'(bus.Rsp_Data), 32'd0);
    chk("rst_exec_ready0", 32'(bus.Req_Ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_exec_no_rsp", 32'(bus.Rsp_Valid), 32'd0);
    end
    bus.Req_Valid      = 2'b11;
    bus.Req_In1[0]     = `WORD_SIZE'(2);
    bus.Req_In2[0]     = `WORD_SIZE'(3);
    bus.Req_Control[0] = ALU_CTRL_ADD;
    #1 chk("rst_exec_regrant0", 32'(bus.Req_Ready), 32'h1);
    @(negedge Clk);
    bus.Req_Valid = '0;
    @(negedge Clk);
    chk("rst_exec_new_valid", 32'(bus.Rsp_Valid), 32'h1);
    chk("rst_exec_new_data", 32'(bus.Rsp_Data), 32'd5);
    bus.Rsp_Ready = 2'b01;
    @(negedge Clk);
    bus.Rsp_Ready = '0;
    chk("final_busy", 32'(bus.Busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
